// File: rtl/psg_register_file.sv
// -----------------------------------------------------------------------------
// psg_register_file
//
// Bus-side front end of the PSG sound block. Decodes the AY-style BDIR/BC1
// bus, holds the sixteen PSG registers R0..R15 and fans their fields out to
// the tone, noise and envelope generators and the mixer. It also produces the
// shared prescale strobe that clocks the tone and noise counters.
//
// Parameters
//   ADDR_HI  upper-nibble chip address; a latched address selects this chip
//            only when da[7:4] matches it
//   DIV      clk_en pulses per clk_div16_en pulse (legal range 2..256)
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   clk_en          PSG master-clock enable, one clk wide
//   bdir, bc1, da   bus: {bdir,bc1} = 00 idle, 01 read, 10 write, 11 latch
//   dout, dout_oe   registered read data and its valid / drive enable
//   clk_div16_en    one-clk strobe every DIV clk_en pulses
//   tone_*_freq     10-bit tone periods {R1[1:0],R0}, {R3[1:0],R2}, {R5[1:0],R4}
//   noise_period    R6[4:0]
//   tone_dis        R7[2:0], active-high disable for channels C,B,A
//   noise_dis       R7[5:3], active-high disable for channels C,B,A
//   amp_a/b/c       R8/R9/R10[4:0]; bit 4 selects the envelope amplitude
//   env_period      {R12,R11}
//   env_shape       R13[3:0]
//   env_restart     one-clk pulse after every accepted R13 write
// -----------------------------------------------------------------------------
module psg_register_file #(
  parameter logic [3:0]  ADDR_HI = 4'h0,
  parameter int unsigned DIV     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        bdir,
  input  logic        bc1,
  input  logic [7:0]  da,
  output logic [7:0]  dout,
  output logic        dout_oe,
  output logic        clk_div16_en,
  output logic [9:0]  tone_a_freq,
  output logic [9:0]  tone_b_freq,
  output logic [9:0]  tone_c_freq,
  output logic [4:0]  noise_period,
  output logic [2:0]  tone_dis,
  output logic [2:0]  noise_dis,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        env_restart
);

  // ---------------------------------------------------------------------------
  // Bus mode decode
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_LATCH = 2'b11
  } bus_mode_e;

  // Register indices that carry special behaviour.
  localparam logic [3:0] REG_ENV_SHAPE = 4'd13;

  // Prescaler terminal count; DIV=256 maps to 8'hFF.
  localparam logic [7:0] CNT_MAX = 8'(DIV - 1);

  bus_mode_e   mode;
  bus_mode_e   prev_mode;
  logic [3:0]  addr;
  logic        sel;
  logic [7:0]  regs [16];
  logic [7:0]  cnt;

  logic        write_fire;
  logic [7:0]  write_data;

  assign mode = bus_mode_e'({bdir, bc1});

  // Bits kept by each register; everything outside the mask is stored as 0,
  // so read-back returns zeros there without any further masking.
  function automatic logic [7:0] store_mask(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
      default:                 return 8'hFF;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Write decode
  //
  // A write phase is recognised on its leading clk only: the current mode is
  // WRITE and the previously sampled mode was not. Holding the bus in WRITE
  // therefore performs exactly one store, and any other mode re-arms it.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    write_fire = 1'b0;
    write_data = 8'h00;
    if ((mode == MODE_WRITE) && (prev_mode != MODE_WRITE) && sel) begin
      write_fire = 1'b1;
      write_data = da & store_mask(addr);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus state: previous mode and latched address / chip select
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_mode <= MODE_IDLE;
      addr      <= 4'h0;
      sel       <= 1'b0;
    end else begin
      prev_mode <= mode;
      if (mode == MODE_LATCH) begin
        addr <= da[3:0];
        sel  <= (da[7:4] == ADDR_HI);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register array
  //
  // Resetting to zero leaves R7 = 0, i.e. every tone and noise channel enabled
  // and all amplitudes silent, which is the state downstream stages expect.
  // ---------------------------------------------------------------------------
  // NOTE: the array is small and its reset value is architecturally visible,
  // so it is built from resettable flops rather than left to a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (write_fire) begin
      regs[addr] <= write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: one clk latency; dout holds its last value between reads so a
  // downstream bus holder sees stable data once dout_oe drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout    <= 8'h00;
      dout_oe <= 1'b0;
    end else if ((mode == MODE_READ) && sel) begin
      dout    <= regs[addr];
      dout_oe <= 1'b1;
    end else begin
      dout_oe <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Envelope restart: pulses on every accepted R13 write, even when the value
  // is unchanged, so software can retrigger the envelope by rewriting R13.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      env_restart <= 1'b0;
    end else begin
      env_restart <= write_fire && (addr == REG_ENV_SHAPE);
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: counts clk_en pulses modulo DIV. The strobe is registered and
  // is raised for the clk following the clk_en at the terminal count; it drops
  // on the next clk because clk_en is itself only one clk wide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= 8'h00;
      clk_div16_en <= 1'b0;
    end else begin
      clk_div16_en <= clk_en && (cnt == CNT_MAX);
      if (clk_en) begin
        cnt <= (cnt == CNT_MAX) ? 8'h00 : cnt + 8'h01;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Field fan-out. R1/R3/R5[3:2] are stored for read-back only: the tone path
  // is 10 bits wide. R14/R15 have no outputs beyond the read port.
  // ---------------------------------------------------------------------------
  assign tone_a_freq  = {regs[1][1:0], regs[0]};
  assign tone_b_freq  = {regs[3][1:0], regs[2]};
  assign tone_c_freq  = {regs[5][1:0], regs[4]};
  assign noise_period = regs[6][4:0];
  assign tone_dis     = regs[7][2:0];
  assign noise_dis    = regs[7][5:3];
  assign amp_a        = regs[8][4:0];
  assign amp_b        = regs[9][4:0];
  assign amp_c        = regs[10][4:0];
  assign env_period   = {regs[12], regs[11]};
  assign env_shape    = regs[13][3:0];

endmodule

// File: tb/tb_psg_register_file.sv
// -----------------------------------------------------------------------------
// tb_psg_register_file
//
// Self-checking bench for psg_register_file: a table of directed bus vectors
// with constant expectations, hand-written sequences for envelope restart,
// prescaler and asynchronous reset, and a randomized phase compared cycle by
// cycle against a behavioural model of the register file.
// -----------------------------------------------------------------------------
module tb_psg_register_file;

  localparam logic [3:0] ADDR_HI = 4'h0;
  localparam int         DIV     = 16;

  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_READ  = 2'b01;
  localparam logic [1:0] M_WRITE = 2'b10;
  localparam logic [1:0] M_LATCH = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        bdir;
  logic        bc1;
  logic [7:0]  da;
  logic [7:0]  dout;
  logic        dout_oe;
  logic        clk_div16_en;
  logic [9:0]  tone_a_freq;
  logic [9:0]  tone_b_freq;
  logic [9:0]  tone_c_freq;
  logic [4:0]  noise_period;
  logic [2:0]  tone_dis;
  logic [2:0]  noise_dis;
  logic [4:0]  amp_a;
  logic [4:0]  amp_b;
  logic [4:0]  amp_c;
  logic [15:0] env_period;
  logic [3:0]  env_shape;
  logic        env_restart;

  psg_register_file #(.ADDR_HI(ADDR_HI), .DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .bdir         (bdir),
    .bc1          (bc1),
    .da           (da),
    .dout         (dout),
    .dout_oe      (dout_oe),
    .clk_div16_en (clk_div16_en),
    .tone_a_freq  (tone_a_freq),
    .tone_b_freq  (tone_b_freq),
    .tone_c_freq  (tone_c_freq),
    .noise_period (noise_period),
    .tone_dis     (tone_dis),
    .noise_dis    (noise_dis),
    .amp_a        (amp_a),
    .amp_b        (amp_b),
    .amp_c        (amp_c),
    .env_period   (env_period),
    .env_shape    (env_shape),
    .env_restart  (env_restart)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the register file as a byte array plus the handful of
  // bus-visible state items, advanced once per clock from the applied inputs.
  // ---------------------------------------------------------------------------
  logic [7:0] m_regs [16];
  logic [3:0] m_addr;
  logic       m_sel;
  logic [1:0] m_prev;
  int         m_cnt;
  logic [7:0] m_dout;
  logic       m_oe;
  logic       m_restart;
  logic       m_pulse;

  function automatic logic [7:0] keep_bits(input int r);
    if (r == 1 || r == 3 || r == 5 || r == 13) return 8'h0F;
    if (r == 6 || r == 8 || r == 9 || r == 10) return 8'h1F;
    return 8'hFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_addr = 4'h0; m_sel = 1'b0; m_prev = M_IDLE; m_cnt = 0;
    m_dout = 8'h00; m_oe = 1'b0; m_restart = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] mode, input logic [7:0] d, input logic en);
    logic new_phase;
    new_phase = (mode == M_WRITE) && (m_prev != M_WRITE);
    m_restart = new_phase && m_sel && (m_addr == 4'd13);
    if (mode == M_READ && m_sel) begin
      m_dout = m_regs[m_addr];
      m_oe   = 1'b1;
    end else begin
      m_oe = 1'b0;
    end
    if (new_phase && m_sel) m_regs[m_addr] = d & keep_bits(int'(m_addr));
    if (mode == M_LATCH) begin
      m_addr = d[3:0];
      m_sel  = (d[7:4] == ADDR_HI);
    end
    m_pulse = en && (m_cnt == DIV - 1);
    if (en) m_cnt = (m_cnt + 1) % DIV;
    m_prev = mode;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"},         dout,         m_dout);
    check({tag, ".dout_oe"},      dout_oe,      m_oe);
    check({tag, ".clk_div16_en"}, clk_div16_en, m_pulse);
    check({tag, ".env_restart"},  env_restart,  m_restart);
    check({tag, ".tone_a"},       tone_a_freq,  {m_regs[1][1:0], m_regs[0]});
    check({tag, ".tone_b"},       tone_b_freq,  {m_regs[3][1:0], m_regs[2]});
    check({tag, ".tone_c"},       tone_c_freq,  {m_regs[5][1:0], m_regs[4]});
    check({tag, ".noise_period"}, noise_period, m_regs[6][4:0]);
    check({tag, ".tone_dis"},     tone_dis,     m_regs[7][2:0]);
    check({tag, ".noise_dis"},    noise_dis,    m_regs[7][5:3]);
    check({tag, ".amp_a"},        amp_a,        m_regs[8][4:0]);
    check({tag, ".amp_b"},        amp_b,        m_regs[9][4:0]);
    check({tag, ".amp_c"},        amp_c,        m_regs[10][4:0]);
    check({tag, ".env_period"},   env_period,   {m_regs[12], m_regs[11]});
    check({tag, ".env_shape"},    env_shape,    m_regs[13][3:0]);
  endtask

  // One bus clock: drive at the negedge, let the DUT and model advance on the
  // posedge, return at the following negedge where outputs are stable.
  task automatic cycle(input logic [1:0] mode, input logic [7:0] d, input logic en);
    bdir = mode[1]; bc1 = mode[0]; da = d; clk_en = en;
    @(posedge clk);
    model_step(mode, d, en);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; bdir = 1'b0; bc1 = 1'b0; da = 8'h00; clk_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef enum int { SIG_NONE, SIG_TONE_A, SIG_RD, SIG_AMP_A, SIG_ENV_P, SIG_NOISE, SIG_DIS } sig_e;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  da;
    sig_e        sig;
    logic [15:0] exp;
    string       name;
  } vec_t;

  function automatic logic [15:0] sample_sig(input sig_e s);
    case (s)
      SIG_TONE_A: return 16'(tone_a_freq);
      SIG_RD:     return 16'({dout_oe, dout});
      SIG_AMP_A:  return 16'(amp_a);
      SIG_ENV_P:  return env_period;
      SIG_NOISE:  return 16'(noise_period);
      SIG_DIS:    return 16'({noise_dis, tone_dis});
      default:    return 16'h0000;
    endcase
  endfunction

  vec_t vecs[$];
  int   pulse_at[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int restarts;
    int width_bad;
    bit last;

    vecs.push_back('{M_LATCH, 8'h00, SIG_NONE,   16'h0000, "latch_r0"});
    vecs.push_back('{M_WRITE, 8'h55, SIG_NONE,   16'h0000, "write_r0"});
    vecs.push_back('{M_IDLE,  8'h00, SIG_NONE,   16'h0000, "idle"});
    vecs.push_back('{M_LATCH, 8'h01, SIG_NONE,   16'h0000, "latch_r1"});
    vecs.push_back('{M_WRITE, 8'hFF, SIG_TONE_A, 16'h0355, "tone_a_355"});
    vecs.push_back('{M_IDLE,  8'h00, SIG_NONE,   16'h0000, "idle"});
    vecs.push_back('{M_READ,  8'h00, SIG_RD,     16'h010F, "read_r1"});
    vecs.push_back('{M_IDLE,  8'h00, SIG_RD,     16'h000F, "read_r1_hold"});
    vecs.push_back('{M_LATCH, 8'h18, SIG_NONE,   16'h0000, "latch_foreign"});
    vecs.push_back('{M_WRITE, 8'h1F, SIG_AMP_A,  16'h0000, "write_blocked"});
    vecs.push_back('{M_IDLE,  8'h00, SIG_NONE,   16'h0000, "idle"});
    vecs.push_back('{M_READ,  8'h00, SIG_RD,     16'h000F, "read_blocked"});
    vecs.push_back('{M_LATCH, 8'h08, SIG_NONE,   16'h0000, "latch_r8"});
    vecs.push_back('{M_WRITE, 8'h1F, SIG_AMP_A,  16'h001F, "amp_a_1f"});
    vecs.push_back('{M_IDLE,  8'h00, SIG_NONE,   16'h0000, "idle"});
    vecs.push_back('{M_LATCH, 8'h0B, SIG_NONE,   16'h0000, "latch_r11"});
    vecs.push_back('{M_WRITE, 8'h34, SIG_NONE,   16'h0000, "write_r11"});
    vecs.push_back('{M_IDLE,  8'h00, SIG_NONE,   16'h0000, "idle"});
    vecs.push_back('{M_LATCH, 8'h0C, SIG_NONE,   16'h0000, "latch_r12"});
    vecs.push_back('{M_WRITE, 8'h12, SIG_ENV_P,  16'h1234, "env_period"});
    vecs.push_back('{M_IDLE,  8'h00, SIG_NONE,   16'h0000, "idle"});
    vecs.push_back('{M_LATCH, 8'h06, SIG_NONE,   16'h0000, "latch_r6"});
    vecs.push_back('{M_WRITE, 8'hFF, SIG_NOISE,  16'h001F, "noise_1f"});
    vecs.push_back('{M_IDLE,  8'h00, SIG_NONE,   16'h0000, "idle"});
    vecs.push_back('{M_READ,  8'h00, SIG_RD,     16'h011F, "read_r6"});
    vecs.push_back('{M_LATCH, 8'h07, SIG_NONE,   16'h0000, "latch_r7"});
    vecs.push_back('{M_WRITE, 8'h2D, SIG_DIS,    16'h002D, "mixer_dis"});
    vecs.push_back('{M_IDLE,  8'h00, SIG_NONE,   16'h0000, "idle"});

    // Reset state
    do_reset();
    @(negedge clk);
    check_all("reset");
    check("reset.tone_dis", tone_dis, 3'b000);
    check("reset.noise_dis", noise_dis, 3'b000);
    check("reset.dout_oe", dout_oe, 1'b0);

    // Directed table
    foreach (vecs[i]) begin
      cycle(vecs[i].mode, vecs[i].da, 1'b0);
      if (vecs[i].sig != SIG_NONE) check(vecs[i].name, sample_sig(vecs[i].sig), vecs[i].exp);
      check_all(vecs[i].name);
    end

    // Envelope restart: a write phase held 5 clk gives one pulse; repeat it
    cycle(M_LATCH, 8'h0D, 1'b0);
    for (int rep = 0; rep < 2; rep++) begin
      restarts = 0;
      for (int k = 0; k < 5; k++) begin
        cycle(M_WRITE, 8'hAB, 1'b0);
        restarts += int'(env_restart);
        check_all("env_hold");
      end
      cycle(M_IDLE, 8'h00, 1'b0);
      restarts += int'(env_restart);
      check("env_restart_count", restarts, 1);
      check("env_shape_b", env_shape, 4'hB);
    end

    // Asynchronous reset in the middle of a write phase
    cycle(M_LATCH, 8'h02, 1'b0);
    bdir = 1'b1; bc1 = 1'b0; da = 8'h77;
    #2 reset = 1'b1;
    #1;
    check("async.tone_a", tone_a_freq, 10'h000);
    check("async.amp_a", amp_a, 5'h00);
    check("async.env_period", env_period, 16'h0000);
    check("async.noise", noise_period, 5'h00);
    check("async.env_shape", env_shape, 4'h0);
    check("async.dout", {dout_oe, dout}, 9'h000);
    bdir = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cycle(M_IDLE, 8'h00, 1'b0);
    check_all("after_async");
    check("async.write_dropped", tone_b_freq, 10'h000);
    cycle(M_LATCH, 8'h02, 1'b0);
    cycle(M_WRITE, 8'h77, 1'b0);
    check("post_reset_write", tone_b_freq, 10'h077);

    // Prescaler: clk_en every 3rd clk for 64 enables
    do_reset();
    width_bad = 0;
    last = 1'b0;
    for (int i = 0; i < 64 * 3; i++) begin
      cycle(M_IDLE, 8'h00, (i % 3) == 0);
      if (clk_div16_en) begin
        pulse_at.push_back(i);
        if (last) width_bad++;
      end
      last = clk_div16_en;
      check_all("presc");
    end
    check("presc.pulse_count", pulse_at.size(), 4);
    for (int p = 1; p < pulse_at.size(); p++) begin
      check("presc.spacing", pulse_at[p] - pulse_at[p - 1], 48);
    end
    check("presc.width", width_bad, 0);
    restarts = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(M_IDLE, 8'h00, 1'b0);
      restarts += int'(clk_div16_en);
    end
    check("presc.idle_pulses", restarts, 0);

    // Randomized bus traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[7:4] = ADDR_HI;
      cycle(2'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)));
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
